// File: rtl/neuron_mem_pkg.sv
// Shared definitions for the synapse weight memory: write modes, clear-FSM
// states and the saturating accumulate used by add-mode commits.
package neuron_mem_pkg;

    localparam logic WR_OVERWRITE = 1'b0;
    localparam logic WR_ADD       = 1'b1;

    typedef enum logic [1:0] {
        CLR_IDLE  = 2'd0,
        CLR_WAIT  = 2'd1,
        CLR_SWEEP = 2'd2
    } clr_state_e;

    // Upper clamp bound for a w-bit two's complement word.
    function automatic logic signed [32:0] sat_hi(input int unsigned w);
        return (33'sd1 <<< (w - 1)) - 33'sd1;
    endfunction

    // Lower clamp bound for a w-bit two's complement word.
    function automatic logic signed [32:0] sat_lo(input int unsigned w);
        return -(33'sd1 <<< (w - 1));
    endfunction

    // Sum of two sign-extended operands, clamped to the w-bit signed range.
    function automatic logic signed [31:0] sat_add(input logic signed [31:0] a,
                                                   input logic signed [31:0] b,
                                                   input int unsigned        w);
        logic signed [32:0] s;
        logic signed [32:0] hi;
        logic signed [32:0] lo;
        s  = {a[31], a} + {b[31], b};
        hi = sat_hi(w);
        lo = sat_lo(w);
        if (s > hi) begin
            return hi[31:0];
        end else if (s < lo) begin
            return lo[31:0];
        end
        return s[31:0];
    endfunction

    // True when sat_add with the same operands had to clamp.
    function automatic logic sat_hit(input logic signed [31:0] a,
                                     input logic signed [31:0] b,
                                     input int unsigned        w);
        logic signed [32:0] s;
        s = {a[31], a} + {b[31], b};
        return (s > sat_hi(w)) || (s < sat_lo(w));
    endfunction

endpackage

// File: rtl/synapse_bank.sv
// One weight bank: DEPTH x DATA_W storage, no reset. The write port has an
// address phase (old-value fetch for read-modify-write, data one cycle later)
// and a commit phase; the read port is synchronous. Reads return the contents
// before any write committed on the same edge.
module synapse_bank #(
    parameter int ADDR_W = 6,
    parameter int DATA_W = 11
) (
    input  logic              clk,
    input  logic [ADDR_W-1:0] i_pre_addr,
    output logic [DATA_W-1:0] o_pre_q,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_waddr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic              i_rd_en,
    input  logic [ADDR_W-1:0] i_raddr,
    output logic [DATA_W-1:0] o_rd_q
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DATA_W-1:0] r_pre_q;
    logic [DATA_W-1:0] r_rd_q;

    // Storage update plus registered old-value fetch and read data.
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
        r_pre_q <= r_mem[i_pre_addr];
        if (i_rd_en) begin
            r_rd_q <= r_mem[i_raddr];
        end
    end

    assign o_pre_q = r_pre_q;
    assign o_rd_q  = r_rd_q;

endmodule

// File: rtl/synapse_weight_ram.sv
// Banked synapse weight store with overwrite / saturating-add writes through a
// one-stage commit pipeline (S1), read forwarding from S1, and a clear FSM
// that zero-sweeps all banks after reset or on request.
module synapse_weight_ram
    import neuron_mem_pkg::*;
#(
    parameter  int NUM_BANKS = 4,
    parameter  int ADDR_W    = 6,
    parameter  int DATA_W    = 11,
    localparam int BANK_W    = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr_start,
    output logic              busy,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic              wr_mode,
    input  logic [BANK_W-1:0] wr_bank,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    input  logic [BANK_W-1:0] rd_bank,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic              sat_pulse
);

    clr_state_e        r_state;
    clr_state_e        w_state_nxt;
    logic [ADDR_W-1:0] r_cnt;
    logic [ADDR_W-1:0] w_cnt_nxt;

    logic              w_idle;
    logic              w_wr_acc;
    logic              w_s1_load;
    logic              w_rd_acc;
    logic              w_rd_oob;

    logic              r_s1_vld;
    logic              r_s1_mode;
    logic [BANK_W-1:0] r_s1_bank;
    logic [ADDR_W-1:0] r_s1_addr;
    logic [DATA_W-1:0] r_s1_data;
    logic              r_s1_fwd;
    logic [DATA_W-1:0] r_s1_fwd_val;

    logic [DATA_W-1:0] w_old_bank;
    logic [DATA_W-1:0] w_old;
    logic [DATA_W-1:0] w_add;
    logic [DATA_W-1:0] w_s1_val;

    logic              r_rd_vld;
    logic              r_rd_oob;
    logic              r_rd_fwd;
    logic [DATA_W-1:0] r_rd_fwd_val;
    logic [BANK_W-1:0] r_rd_bank;
    logic [DATA_W-1:0] r_rd_last;
    logic [DATA_W-1:0] w_rd_bank_q;
    logic [DATA_W-1:0] w_rd_now;

    logic              w_bank_we [NUM_BANKS];
    logic [ADDR_W-1:0] w_bank_waddr;
    logic [DATA_W-1:0] w_bank_wdata;
    logic [DATA_W-1:0] w_pre_q    [NUM_BANKS];
    logic [DATA_W-1:0] w_rd_q     [NUM_BANKS];

    assign w_idle    = (r_state == CLR_IDLE);
    assign busy      = !w_idle;
    assign wr_ready  = w_idle;
    assign w_wr_acc  = wr_valid && w_idle;
    assign w_s1_load = w_wr_acc && (32'(wr_bank) < 32'(NUM_BANKS));
    assign w_rd_acc  = rd_en && w_idle;
    assign w_rd_oob  = (32'(rd_bank) >= 32'(NUM_BANKS));

    // Clear FSM and sweep address register; reset restarts the sweep.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= CLR_SWEEP;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Clear FSM next state: WAIT lets the last accepted write commit first.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            CLR_IDLE: begin
                if (clr_start) begin
                    w_state_nxt = CLR_WAIT;
                end
            end
            CLR_WAIT: begin
                if (!w_s1_load) begin
                    w_state_nxt = CLR_SWEEP;
                    w_cnt_nxt   = '0;
                end
            end
            CLR_SWEEP: begin
                w_cnt_nxt = r_cnt + 1'b1;
                if (r_cnt == '1) begin
                    w_state_nxt = CLR_IDLE;
                end
            end
            default: begin
                w_state_nxt = CLR_SWEEP;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    // S1 stage: capture accepted write and whether its old value must come
    // from the write committing in the same cycle instead of the bank.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_vld     <= 1'b0;
            r_s1_mode    <= WR_OVERWRITE;
            r_s1_bank    <= '0;
            r_s1_addr    <= '0;
            r_s1_data    <= '0;
            r_s1_fwd     <= 1'b0;
            r_s1_fwd_val <= '0;
        end else begin
            r_s1_vld     <= w_s1_load;
            r_s1_mode    <= wr_mode;
            r_s1_bank    <= wr_bank;
            r_s1_addr    <= wr_addr;
            r_s1_data    <= wr_data;
            r_s1_fwd     <= r_s1_vld && (r_s1_bank == wr_bank) && (r_s1_addr == wr_addr);
            r_s1_fwd_val <= w_s1_val;
        end
    end

    // S1 commit value: overwrite or saturating add onto the (forwarded) old word.
    always_comb begin
        w_old_bank = '0;
        for (int unsigned b = 0; b < NUM_BANKS; b++) begin
            if (r_s1_bank == BANK_W'(b)) begin
                w_old_bank = w_pre_q[b];
            end
        end
        w_old    = r_s1_fwd ? r_s1_fwd_val : w_old_bank;
        w_add    = DATA_W'(sat_add(32'(signed'(w_old)), 32'(signed'(r_s1_data)), DATA_W));
        w_s1_val = (r_s1_mode == WR_ADD) ? w_add : r_s1_data;
    end

    assign sat_pulse = r_s1_vld && (r_s1_mode == WR_ADD) &&
                       sat_hit(32'(signed'(w_old)), 32'(signed'(r_s1_data)), DATA_W);

    // Bank write arbitration: the sweep owns every bank, otherwise S1 commits.
    always_comb begin
        w_bank_waddr = r_s1_addr;
        w_bank_wdata = w_s1_val;
        for (int unsigned b = 0; b < NUM_BANKS; b++) begin
            w_bank_we[b] = r_s1_vld && (r_s1_bank == BANK_W'(b));
        end
        if (r_state == CLR_SWEEP) begin
            w_bank_waddr = r_cnt;
            w_bank_wdata = '0;
            for (int unsigned b = 0; b < NUM_BANKS; b++) begin
                w_bank_we[b] = 1'b1;
            end
        end
    end

    for (genvar g = 0; g < NUM_BANKS; g++) begin : g_bank
        synapse_bank #(
            .ADDR_W (ADDR_W),
            .DATA_W (DATA_W)
        ) u_bank (
            .clk        (clk),
            .i_pre_addr (wr_addr),
            .o_pre_q    (w_pre_q[g]),
            .i_we       (w_bank_we[g]),
            .i_waddr    (w_bank_waddr),
            .i_wdata    (w_bank_wdata),
            .i_rd_en    (w_rd_acc),
            .i_raddr    (rd_addr),
            .o_rd_q     (w_rd_q[g])
        );
    end

    // Read qualifier and sideband: forward the write committing during the read cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_vld     <= 1'b0;
            r_rd_oob     <= 1'b0;
            r_rd_fwd     <= 1'b0;
            r_rd_fwd_val <= '0;
            r_rd_bank    <= '0;
        end else begin
            r_rd_vld <= w_rd_acc;
            if (w_rd_acc) begin
                r_rd_oob     <= w_rd_oob;
                r_rd_fwd     <= r_s1_vld && (r_s1_bank == rd_bank) && (r_s1_addr == rd_addr);
                r_rd_fwd_val <= w_s1_val;
                r_rd_bank    <= rd_bank;
            end
        end
    end

    // Select the word for the read that completed this cycle.
    always_comb begin
        w_rd_bank_q = '0;
        for (int unsigned b = 0; b < NUM_BANKS; b++) begin
            if (r_rd_bank == BANK_W'(b)) begin
                w_rd_bank_q = w_rd_q[b];
            end
        end
        if (r_rd_oob) begin
            w_rd_now = '0;
        end else if (r_rd_fwd) begin
            w_rd_now = r_rd_fwd_val;
        end else begin
            w_rd_now = w_rd_bank_q;
        end
    end

    // Hold the last returned word so rd_data is stable between reads.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_last <= '0;
        end else if (r_rd_vld) begin
            r_rd_last <= w_rd_now;
        end
    end

    assign rd_valid = r_rd_vld;
    assign rd_data  = r_rd_vld ? w_rd_now : r_rd_last;

endmodule

// File: tb/tb_synapse_weight_ram.sv
// Self-checking bench for synapse_weight_ram (default parameters). A plain
// array model applies each accepted write immediately in acceptance order;
// reads see the model before the same cycle's write.
module tb_synapse_weight_ram;

    logic        clk;
    logic        rst_n;
    logic        clr_start;
    logic        busy;
    logic        wr_valid;
    logic        wr_ready;
    logic        wr_mode;
    logic [1:0]  wr_bank;
    logic [5:0]  wr_addr;
    logic [10:0] wr_data;
    logic        rd_en;
    logic [1:0]  rd_bank;
    logic [5:0]  rd_addr;
    logic [10:0] rd_data;
    logic        rd_valid;
    logic        sat_pulse;

    int checks;
    int failures;

    int mdl [4][64];
    int m_busy;
    int exp_rd;
    bit exp_rdv;
    bit exp_sat;

    synapse_weight_ram #(
        .NUM_BANKS (4),
        .ADDR_W    (6),
        .DATA_W    (11)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr_start (clr_start),
        .busy      (busy),
        .wr_valid  (wr_valid),
        .wr_ready  (wr_ready),
        .wr_mode   (wr_mode),
        .wr_bank   (wr_bank),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .rd_en     (rd_en),
        .rd_bank   (rd_bank),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .rd_valid  (rd_valid),
        .sat_pulse (sat_pulse)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic model_zero();
        for (int b = 0; b < 4; b++)
            for (int a = 0; a < 64; a++)
                mdl[b][a] = 0;
    endtask

    // One clock cycle of stimulus; updates the model and expectations.
    task automatic cycle(input bit wv, input bit wm, input int wb, input int wa, input int wd,
                         input bit re, input int rb, input int ra, input bit clr);
        bit free;
        int s;
        int v;
        free      = (m_busy == 0);
        wr_valid  = wv;
        wr_mode   = wm;
        wr_bank   = 2'(wb);
        wr_addr   = 6'(wa);
        wr_data   = 11'(wd);
        rd_en     = re;
        rd_bank   = 2'(rb);
        rd_addr   = 6'(ra);
        clr_start = clr;
        exp_rdv   = re && free;
        if (exp_rdv) exp_rd = mdl[rb][ra];
        exp_sat = 1'b0;
        if (wv && free) begin
            if (!wm) begin
                v = wd;
            end else begin
                s = mdl[wb][wa] + wd;
                v = s;
                if (s > 1023)  v = 1023;
                if (s < -1024) v = -1024;
                exp_sat = (v != s);
            end
            mdl[wb][wa] = v;
        end
        @(posedge clk);
        if (clr && free) begin
            model_zero();
            m_busy = 65;
        end else if (m_busy > 0) begin
            m_busy--;
        end
        #1;
        wr_valid  = 1'b0;
        rd_en     = 1'b0;
        clr_start = 1'b0;
    endtask

    task automatic test_reset();
        int n;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (busy !== 1'b1)     begin failures++; $display("FAIL reset_busy got=%b exp=1", busy); end
        checks++; if (wr_ready !== 1'b0) begin failures++; $display("FAIL reset_wr_ready got=%b exp=0", wr_ready); end
        checks++; if (rd_valid !== 1'b0) begin failures++; $display("FAIL reset_rd_valid got=%b exp=0", rd_valid); end
        checks++; if (rd_data !== 11'd0) begin failures++; $display("FAIL reset_rd_data got=%0d exp=0", rd_data); end
        checks++; if (sat_pulse !== 1'b0) begin failures++; $display("FAIL reset_sat_pulse got=%b exp=0", sat_pulse); end
        rst_n = 1'b1;
        n = 0;
        while (busy === 1'b1 && n < 200) begin
            n++;
            @(posedge clk);
            #1;
        end
        checks++; if (n != 64) begin failures++; $display("FAIL reset_sweep_len got=%0d exp=64", n); end
        model_zero();
        m_busy = 0;
        exp_rd = 0;
    endtask

    task automatic test_clear_contents();
        for (int b = 0; b < 4; b++) begin
            for (int a = 0; a < 64; a++) begin
                cycle(0, 0, 0, 0, 0, 1, b, a, 0);
                checks++;
                if (rd_valid !== 1'b1 || $signed(rd_data) !== exp_rd) begin
                    failures++;
                    $display("FAIL cleared_word b=%0d a=%0d got_v=%b got=%0d exp=%0d", b, a, rd_valid, $signed(rd_data), exp_rd);
                end
            end
        end
    endtask

    task automatic test_forward_read();
        cycle(1, 0, 2, 5, 300, 0, 0, 0, 0);
        cycle(0, 0, 0, 0, 0, 1, 2, 5, 0);
        checks++; if (rd_valid !== 1'b1) begin failures++; $display("FAIL fwd_rd_valid got=%b exp=1", rd_valid); end
        checks++; if ($signed(rd_data) !== 300) begin failures++; $display("FAIL fwd_rd_data got=%0d exp=300", $signed(rd_data)); end
    endtask

    task automatic test_accumulate();
        for (int i = 0; i < 3; i++) begin
            cycle(1, 1, 1, 0, 100, 0, 0, 0, 0);
            checks++; if (sat_pulse !== 1'b0) begin failures++; $display("FAIL acc_sat i=%0d got=%b exp=0", i, sat_pulse); end
        end
        cycle(0, 0, 0, 0, 0, 1, 1, 0, 0);
        checks++; if ($signed(rd_data) !== 300) begin failures++; $display("FAIL acc_fwd got=%0d exp=300", $signed(rd_data)); end
        cycle(0, 0, 0, 0, 0, 1, 1, 0, 0);
        checks++; if ($signed(rd_data) !== 300) begin failures++; $display("FAIL acc_stored got=%0d exp=300", $signed(rd_data)); end
    endtask

    task automatic test_saturation();
        int sats;
        sats = 0;
        cycle(1, 0, 0, 10, 1000, 0, 0, 0, 0);
        if (sat_pulse === 1'b1) sats++;
        cycle(1, 1, 0, 10, 100, 0, 0, 0, 0);
        if (sat_pulse === 1'b1) sats++;
        cycle(0, 0, 0, 0, 0, 1, 0, 10, 0);
        if (sat_pulse === 1'b1) sats++;
        checks++; if (sats != 1) begin failures++; $display("FAIL sat_hi_pulses got=%0d exp=1", sats); end
        checks++; if ($signed(rd_data) !== 1023) begin failures++; $display("FAIL sat_hi_val got=%0d exp=1023", $signed(rd_data)); end
        sats = 0;
        cycle(1, 0, 3, 20, -1000, 0, 0, 0, 0);
        if (sat_pulse === 1'b1) sats++;
        cycle(1, 1, 3, 20, -100, 0, 0, 0, 0);
        if (sat_pulse === 1'b1) sats++;
        cycle(0, 0, 0, 0, 0, 1, 3, 20, 0);
        if (sat_pulse === 1'b1) sats++;
        checks++; if (sats != 1) begin failures++; $display("FAIL sat_lo_pulses got=%0d exp=1", sats); end
        checks++; if ($signed(rd_data) !== -1024) begin failures++; $display("FAIL sat_lo_val got=%0d exp=-1024", $signed(rd_data)); end
    endtask

    task automatic test_random();
        int wd;
        for (int i = 0; i < 400; i++) begin
            wd = ($urandom_range(3, 0) == 0) ? int'($urandom_range(2047, 0)) - 1024
                                             : int'($urandom_range(600, 0)) - 300;
            cycle(bit'($urandom_range(1, 0)), bit'($urandom_range(1, 0)),
                  int'($urandom_range(3, 0)), int'($urandom_range(7, 0)), wd,
                  bit'($urandom_range(1, 0)), int'($urandom_range(3, 0)), int'($urandom_range(7, 0)), 0);
            checks++;
            if (rd_valid !== exp_rdv || $signed(rd_data) !== exp_rd) begin
                failures++;
                $display("FAIL rand_rd i=%0d got_v=%b got=%0d exp_v=%b exp=%0d", i, rd_valid, $signed(rd_data), exp_rdv, exp_rd);
            end
            checks++;
            if (sat_pulse !== exp_sat) begin
                failures++;
                $display("FAIL rand_sat i=%0d got=%b exp=%b", i, sat_pulse, exp_sat);
            end
        end
    endtask

    task automatic test_clear_with_write();
        int n;
        cycle(1, 0, 2, 5, 300, 0, 0, 0, 0);
        cycle(0, 0, 0, 0, 0, 1, 2, 5, 0);
        checks++; if ($signed(rd_data) !== 300) begin failures++; $display("FAIL pre_clear_rd got=%0d exp=300", $signed(rd_data)); end
        n = 0;
        cycle(1, 0, 0, 63, 7, 0, 0, 0, 1);
        if (busy === 1'b1) n++;
        cycle(0, 0, 0, 0, 0, 1, 0, 63, 0);
        if (busy === 1'b1) n++;
        checks++; if (rd_valid !== 1'b0) begin failures++; $display("FAIL busy_rd_valid got=%b exp=0", rd_valid); end
        checks++; if ($signed(rd_data) !== exp_rd) begin failures++; $display("FAIL busy_rd_hold got=%0d exp=%0d", $signed(rd_data), exp_rd); end
        while (busy === 1'b1 && n < 300) begin
            cycle(0, 0, 0, 0, 0, 0, 0, 0, 0);
            if (busy === 1'b1) n++;
        end
        checks++; if (n != 65) begin failures++; $display("FAIL clear_busy_len got=%0d exp=65", n); end
        cycle(0, 0, 0, 0, 0, 1, 0, 63, 0);
        checks++; if (rd_valid !== 1'b1 || $signed(rd_data) !== 0) begin failures++; $display("FAIL clear_word63 got=%0d exp=0", $signed(rd_data)); end
        cycle(0, 0, 0, 0, 0, 1, 2, 5, 0);
        checks++; if ($signed(rd_data) !== 0) begin failures++; $display("FAIL clear_word_b2a5 got=%0d exp=0", $signed(rd_data)); end
    endtask

    task automatic test_reset_mid_sweep();
        int n;
        cycle(1, 0, 1, 50, 123, 0, 0, 0, 0);
        cycle(1, 1, 3, 9, 40, 0, 0, 0, 0);
        rst_n = 1'b0;
        #1;
        checks++; if (sat_pulse !== 1'b0 || busy !== 1'b1 || wr_ready !== 1'b0) begin
            failures++; $display("FAIL s1_reset got_sat=%b got_busy=%b got_rdy=%b exp=0,1,0", sat_pulse, busy, wr_ready);
        end
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (30) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        n = 0;
        while (busy === 1'b1 && n < 200) begin
            n++;
            @(posedge clk);
            #1;
        end
        checks++; if (n != 64) begin failures++; $display("FAIL restart_sweep_len got=%0d exp=64", n); end
        model_zero();
        m_busy = 0;
        exp_rd = 0;
        cycle(0, 0, 0, 0, 0, 1, 3, 9, 0);
        checks++; if (rd_valid !== 1'b1 || $signed(rd_data) !== 0) begin failures++; $display("FAIL lost_add_word got=%0d exp=0", $signed(rd_data)); end
        cycle(0, 0, 0, 0, 0, 1, 1, 50, 0);
        checks++; if ($signed(rd_data) !== 0) begin failures++; $display("FAIL resweep_word got=%0d exp=0", $signed(rd_data)); end
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        rst_n     = 1'b0;
        clr_start = 1'b0;
        wr_valid  = 1'b0;
        wr_mode   = 1'b0;
        wr_bank   = '0;
        wr_addr   = '0;
        wr_data   = '0;
        rd_en     = 1'b0;
        rd_bank   = '0;
        rd_addr   = '0;
        m_busy    = 64;
        exp_rd    = 0;
        exp_rdv   = 1'b0;
        exp_sat   = 1'b0;
        model_zero();
        test_reset();
        test_clear_contents();
        test_forward_read();
        test_accumulate();
        test_saturation();
        test_random();
        test_clear_with_write();
        test_reset_mid_sweep();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/synapse_weight_ram.md
SYNAPSE_WEIGHT_RAM -- requirements
Module: synapse_weight_ram

Interface
REQ-001 SHALL have parameter NUM_BANKS, default 4: independent weight banks, one per presynaptic group.
REQ-002 SHALL have parameter ADDR_W, default 6: address width; DEPTH = 2**ADDR_W words per bank.
REQ-003 SHALL have parameter DATA_W, default 11: signed weight width, two's complement.
REQ-004 SHALL derive BANK_W = max(1, clog2(NUM_BANKS)).
REQ-005 clk  in  1  single clock, all logic on rising edge.
REQ-006 rst_n  in  1  reset, asynchronous, active-low.
REQ-007 clr_start  in  1  request a full clear of all banks.
REQ-008 busy  out  1  high while a clear is pending or sweeping.
REQ-009 wr_valid / wr_ready  in / out  1 / 1  write request handshake.
REQ-010 wr_mode  in  1  0 = overwrite, 1 = saturating add of wr_data to the stored weight.
REQ-011 wr_bank / wr_addr / wr_data  in  BANK_W / ADDR_W / DATA_W  write target and operand.
REQ-012 rd_en / rd_bank / rd_addr  in  1 / BANK_W / ADDR_W  read request.
REQ-013 rd_data / rd_valid  out  DATA_W / 1  registered read result and qualifier.
REQ-014 sat_pulse  out  1  one-cycle pulse when an add commit clamps.

Function
REQ-015 Write is accepted in cycle A when wr_valid && wr_ready; wr_ready = !busy.
REQ-016 Accepted write SHALL occupy stage S1 in cycle A+1 and commit to the bank at the end of A+1.
REQ-017 Overwrite commit value = wr_data; add commit value = sat(old + wr_data), where the sum uses DATA_W+1 bits and clamps to [-2**(DATA_W-1), 2**(DATA_W-1)-1].
REQ-018 old SHALL be the S1 commit value when S1 holds the same bank/addr (forwarding), otherwise the bank contents; back-to-back adds to one address accumulate exactly.
REQ-019 sat_pulse SHALL be high during the S1 cycle whose add result clamped; it is 0 for overwrites.
REQ-020 Read issued in cycle R (rd_en && !busy) SHALL give rd_valid = 1 and rd_data in cycle R+1.
REQ-021 rd_data SHALL reflect every write accepted before cycle R, including the write in S1 during R (forwarded), and no write accepted in R.
REQ-022 rd_en while busy is ignored: rd_valid = 0 next cycle, rd_data holds its previous value.
REQ-023 Out-of-range bank index (>= NUM_BANKS) SHALL drop a write silently, and SHALL make a read return 0 with rd_valid = 1.
REQ-024 Clear FSM states: IDLE, WAIT (S1 draining), SWEEP; busy = (state != IDLE).
REQ-025 IDLE -> WAIT on clr_start; WAIT -> SWEEP when S1 is empty; SWEEP writes 0 to address k in all banks in sweep cycle k, and goes to IDLE after k = DEPTH-1.
REQ-026 clr_start while busy is ignored; the clear takes DEPTH cycles of SWEEP plus at most 1 cycle of WAIT.
REQ-027 A write accepted in the cycle clr_start rises SHALL commit before the sweep and is then cleared.

Reset
REQ-028 rst_n low SHALL immediately force rd_valid = 0, rd_data = 0, sat_pulse = 0, S1 empty, sweep counter = 0, state = SWEEP (busy = 1, wr_ready = 0).
REQ-029 After rst_n release, the module SHALL sweep DEPTH cycles, then enter IDLE with every word equal to 0.
REQ-030 Reset asserted during a sweep or with S1 full SHALL discard S1 and restart the sweep at address 0; the storage arrays themselves are not reset.

Structure
REQ-031 Package neuron_mem_pkg SHALL hold the WR_OVERWRITE/WR_ADD mode constants, the clear-FSM state typedef and the saturating-add function.
REQ-032 A sub-module synapse_bank (1 write port, 1 synchronous read port, DEPTH x DATA_W, no reset) SHALL be instantiated NUM_BANKS times.
REQ-033 Control (S1, forwarding, FSM) SHALL live in synapse_weight_ram only.

Verification (defaults)
REQ-034 Release reset -> busy high exactly 64 cycles; then reading all 4x64 words returns 0.
REQ-035 Overwrite bank 2 addr 5 = 300, then read it the next cycle -> rd_data = 300 (forwarded), rd_valid = 1.
REQ-036 Add 100 three times back-to-back to bank 1 addr 0 (starting from 0) -> final value 300, sat_pulse never high.
REQ-037 Overwrite 1000, then add 100 -> stored value 1023 and one sat_pulse; overwrite -1000, then add -100 -> stored value -1024 and one sat_pulse.
REQ-038 clr_start in the same cycle a write of 7 to bank 0 addr 63 is accepted -> busy stays high 65 cycles, and the word then reads 0.
REQ-039 Pull rst_n low at sweep address 30 with an add in S1 -> the add is lost and the sweep restarts at 0, taking 64 cycles.
